// File: rtl/photon_fifo_merger_hls_deadlock_report_pkg.sv
// Shared types and defaults for the FIFO-merger deadlock reporter.
// The free-running timestamp is built only when DEADLOCK_REPORT_TIMESTAMP_EN is defined.
package photon_fifo_merger_deadlock_pkg;

    localparam int STATE_W       = 2;
    localparam int DEF_THRESHOLD = 1024;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DETECTED = 2'd2,
        ST_REPORTED = 2'd3
    } state_t;

    // Index width for a monitor vector; a single monitor still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/photon_fifo_merger_hls_deadlock_report_if.sv
// Report handshake bundle: the reporter drives valid and payload, the consumer drives ready.
interface photon_fifo_merger_hls_deadlock_report_if #(
    parameter int IDX_W = 2
);
    logic             report_valid;
    logic             report_ready;
    logic [IDX_W-1:0] deadlock_idx;
    logic [31:0]      report_timestamp;

    modport master (
        output report_valid,
        output deadlock_idx,
        output report_timestamp,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  deadlock_idx,
        input  report_timestamp,
        output report_ready
    );
endinterface

// File: rtl/photon_fifo_merger_hls_deadlock_report_lsb_encoder.sv
// Combinational lowest-set-bit encoder over the monitor block vector.
module photon_fifo_merger_lsb_encoder
    import photon_fifo_merger_deadlock_pkg::*;
#(
    parameter  int NUM_MONITORS = 4,
    localparam int IDX_W        = idx_width(NUM_MONITORS)
) (
    input  logic [NUM_MONITORS-1:0] vec,
    output logic [IDX_W-1:0]        idx,
    output logic                    any
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx = '0;
        for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/photon_fifo_merger_hls_deadlock_report.sv
// Deadlock detector/reporter for merged HLS FIFO monitors; optional timestamp
// under DEADLOCK_REPORT_TIMESTAMP_EN (otherwise report_timestamp is tied to 0).
module photon_fifo_merger_hls_deadlock_report
    import photon_fifo_merger_deadlock_pkg::*;
#(
    parameter int NUM_MONITORS = 4,
    parameter int THRESHOLD    = DEF_THRESHOLD,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_MONITORS-1:0] block_in,
    input  logic                    clear,
    output logic                    deadlock,
    output logic [CNT_W-1:0]        stall_cycles,
    photon_fifo_merger_hls_deadlock_report_if.master rpt
);

    localparam int               IDX_W   = idx_width(NUM_MONITORS);
    localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESHOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stall_reg, stall_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [31:0]      ts_reg, ts_next;
    logic [31:0]      tick_now;
    logic [IDX_W-1:0] lsb_idx;
    logic             any_block;

    photon_fifo_merger_lsb_encoder #(
        .NUM_MONITORS(NUM_MONITORS)
    ) u_lsb_encoder (
        .vec(block_in),
        .idx(lsb_idx),
        .any(any_block)
    );

`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
    logic [31:0] tick_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + 32'd1;
        end
    end

    // Value the counter takes on this edge, so detection on edge N reports N.
    assign tick_now = tick_reg + 32'd1;
`else
    assign tick_now = 32'd0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            stall_reg <= '0;
            idx_reg   <= '0;
            ts_reg    <= '0;
        end else begin
            state_reg <= state_next;
            stall_reg <= stall_next;
            idx_reg   <= idx_next;
            ts_reg    <= ts_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_next = stall_reg;
        idx_next   = idx_reg;
        ts_next    = ts_reg;

        if (clear) begin
            state_next = ST_IDLE;
            stall_next = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (any_block) begin
                        state_next = ST_SUSPECT;
                        stall_next = CNT_ONE;
                        idx_next   = lsb_idx;
                    end
                end
                ST_SUSPECT: begin
                    if (!any_block) begin
                        state_next = ST_IDLE;
                        stall_next = '0;
                    end else begin
                        stall_next = stall_reg + CNT_ONE;
                        if (stall_reg == THR_M1) begin
                            state_next = ST_DETECTED;
                            ts_next    = tick_now;
                        end
                    end
                end
                ST_DETECTED, ST_REPORTED: begin
                    if (state_reg == ST_DETECTED && rpt.report_ready) begin
                        state_next = ST_REPORTED;
                    end
                    // After detection the count only records how long the stall lasted.
                    if (any_block && stall_reg != CNT_MAX) begin
                        stall_next = stall_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    stall_next = '0;
                end
            endcase
        end
    end

    assign deadlock             = (state_reg == ST_DETECTED) || (state_reg == ST_REPORTED);
    assign stall_cycles         = stall_reg;
    assign rpt.report_valid     = (state_reg == ST_DETECTED);
    assign rpt.deadlock_idx     = idx_reg;
    assign rpt.report_timestamp = ts_reg;

endmodule

// File: tb/tb_photon_fifo_merger_hls_deadlock_report.sv
// Self-checking bench for the deadlock reporter (THRESHOLD=8, NUM_MONITORS=4, CNT_W=4).
module tb_photon_fifo_merger_hls_deadlock_report;

    localparam int THR  = 8;
    localparam int NMON = 4;
    localparam int CW   = 4;
    localparam int SMAX = 15;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NMON-1:0] block_in = '0;
    logic            clear = 1'b0;
    logic            deadlock;
    logic [CW-1:0]   stall_cycles;

    photon_fifo_merger_hls_deadlock_report_if #(.IDX_W(2)) rpt ();

    photon_fifo_merger_hls_deadlock_report #(
        .NUM_MONITORS(NMON),
        .THRESHOLD(THR),
        .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .block_in(block_in),
        .clear(clear),
        .deadlock(deadlock),
        .stall_cycles(stall_cycles),
        .rpt(rpt)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: run length of the current stall plus "declared"/"reported" flags.
    int          m_run;
    bit          m_latched;
    bit          m_reported;
    logic [1:0]  m_idx;
    logic [31:0] m_ts;
    int          m_edges;

    function automatic logic [1:0] lowest(input logic [NMON-1:0] b);
        for (int i = 0; i < NMON; i++) begin
            if (b[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_latched = 0; m_reported = 0;
        m_idx = '0; m_ts = '0; m_edges = 0;
    endtask

    task automatic model_step(input logic [NMON-1:0] b, input bit clr, input bit rdy);
        m_edges++;
        if (clr) begin
            m_latched = 0; m_reported = 0; m_run = 0;
        end else if (!m_latched) begin
            if (b == 0) begin
                m_run = 0;
            end else begin
                if (m_run == 0) m_idx = lowest(b);
                m_run++;
                if (m_run == THR) begin
                    m_latched = 1;
`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
                    m_ts = 32'(m_edges);
`else
                    m_ts = 32'd0;
`endif
                end
            end
        end else begin
            if (!m_reported && rdy) m_reported = 1;
            if (b != 0 && m_run < SMAX) m_run++;
        end
    endtask

    // Apply inputs, take one rising edge, advance the model, sample 1ns later.
    task automatic cycle(input logic [NMON-1:0] b, input bit clr, input bit rdy);
        block_in = b; clear = clr; rpt.report_ready = rdy;
        @(posedge clock);
        model_step(b, clr, rdy);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; block_in = '0; clear = 1'b0; rpt.report_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0; block_in = 4'hF; clear = 1'b0; rpt.report_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total_cnt++; if (deadlock !== 1'b0) $display("FAIL reset_deadlock got=%b want=0", deadlock); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'd0) $display("FAIL reset_stall got=%0d want=0", stall_cycles); else pass_cnt++;
        total_cnt++; if (rpt.report_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", rpt.report_valid); else pass_cnt++;
        total_cnt++; if (rpt.deadlock_idx !== 2'd0) $display("FAIL reset_idx got=%0d want=0", rpt.deadlock_idx); else pass_cnt++;
        total_cnt++; if (rpt.report_timestamp !== 32'd0) $display("FAIL reset_ts got=%0d want=0", rpt.report_timestamp); else pass_cnt++;
        $display("test_reset: outputs checked while reset held low");
        do_reset();
    endtask

    task automatic test_detect();
        do_reset();
        for (int k = 1; k <= THR; k++) begin
            cycle(4'b0110, 0, 0);
            total_cnt++;
            if (deadlock !== m_latched || stall_cycles !== 4'(m_run))
                $display("FAIL detect_run k=%0d deadlock=%b stall=%0d want %b/%0d", k, deadlock, stall_cycles, m_latched, m_run);
            else pass_cnt++;
        end
        total_cnt++;
        if (deadlock !== 1'b1 || rpt.report_valid !== 1'b1 || rpt.deadlock_idx !== 2'd1 || stall_cycles !== 4'd8)
            $display("FAIL detect_final deadlock=%b valid=%b idx=%0d stall=%0d want 1/1/1/8",
                     deadlock, rpt.report_valid, rpt.deadlock_idx, stall_cycles);
        else pass_cnt++;
        $display("test_detect: 0110 for %0d cycles, deadlock=%b idx=%0d stall=%0d", THR, deadlock, rpt.deadlock_idx, stall_cycles);
    endtask

    task automatic test_gap();
        logic [NMON-1:0] b;
        bit ever = 0;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            b = (k == 7) ? 4'd0 : 4'($urandom_range(1, 15));
            cycle(b, 0, 0);
            if (deadlock) ever = 1;
            if (k == 7) begin
                total_cnt++;
                if (stall_cycles !== 4'd0) $display("FAIL gap_stall got=%0d want=0", stall_cycles); else pass_cnt++;
            end
        end
        total_cnt++; if (ever) $display("FAIL gap_deadlock got=1 want=0"); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'd7) $display("FAIL gap_end_stall got=%0d want=7", stall_cycles); else pass_cnt++;
        $display("test_gap: 7 high, 1 low, 7 high, stall=%0d", stall_cycles);
    endtask

    task automatic test_handshake();
        logic [1:0]  idx0;
        logic [31:0] ts0;
        bit stable = 1;
        do_reset();
        repeat (THR) cycle(4'b1000, 0, 0);
        idx0 = rpt.deadlock_idx; ts0 = rpt.report_timestamp;
        total_cnt++; if (idx0 !== 2'd3) $display("FAIL hs_idx got=%0d want=3", idx0); else pass_cnt++;
        repeat (5) begin
            cycle(4'($urandom_range(0, 15)), 0, 0);
            if (rpt.report_valid !== 1'b1 || rpt.deadlock_idx !== idx0 || rpt.report_timestamp !== ts0) stable = 0;
        end
        total_cnt++; if (!stable) $display("FAIL hs_stable fields changed while ready low"); else pass_cnt++;
        cycle(4'b0001, 0, 1);
        total_cnt++;
        if (rpt.report_valid !== 1'b0 || deadlock !== 1'b1)
            $display("FAIL hs_accept valid=%b deadlock=%b want 0/1", rpt.report_valid, deadlock);
        else pass_cnt++;
        cycle(4'b0001, 0, 1);
        total_cnt++; if (rpt.report_valid !== 1'b0) $display("FAIL hs_one_shot valid=%b want 0", rpt.report_valid); else pass_cnt++;
        $display("test_handshake: ready low 5 then high, valid=%b deadlock=%b", rpt.report_valid, deadlock);
    endtask

    task automatic test_saturate_clear();
        do_reset();
        repeat (20) cycle(4'b0001, 0, 0);
        total_cnt++; if (stall_cycles !== 4'd15) $display("FAIL sat_stall got=%0d want=15", stall_cycles); else pass_cnt++;
        cycle(4'b0001, 1, 0);
        total_cnt++;
        if (deadlock !== 1'b0 || stall_cycles !== 4'd0 || rpt.report_valid !== 1'b0)
            $display("FAIL clear_out deadlock=%b stall=%0d valid=%b want 0/0/0", deadlock, stall_cycles, rpt.report_valid);
        else pass_cnt++;
        cycle(4'b0100, 0, 0);
        total_cnt++;
        if (stall_cycles !== 4'd1 || rpt.deadlock_idx !== 2'd2)
            $display("FAIL clear_rearm stall=%0d idx=%0d want 1/2", stall_cycles, rpt.deadlock_idx);
        else pass_cnt++;
        $display("test_saturate_clear: saturated, cleared, rearmed stall=%0d", stall_cycles);
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) cycle(4'b0010, 0, 0);
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (stall_cycles !== 4'd0 || deadlock !== 1'b0 || rpt.report_valid !== 1'b0 || rpt.deadlock_idx !== 2'd0)
            $display("FAIL async_reset stall=%0d deadlock=%b valid=%b idx=%0d want all 0",
                     stall_cycles, deadlock, rpt.report_valid, rpt.deadlock_idx);
        else pass_cnt++;
        $display("test_async_reset: reset asserted between edges, stall=%0d", stall_cycles);
        do_reset();
    endtask

    task automatic test_timestamp();
        logic [31:0] want;
`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
        want = 32'd100;
`else
        want = 32'd0;
`endif
        do_reset();
        repeat (100 - THR) cycle(4'b0000, 0, 0);
        repeat (THR) cycle(4'b0010, 0, 0);
        total_cnt++;
        if (deadlock !== 1'b1 || rpt.report_timestamp !== want)
            $display("FAIL timestamp deadlock=%b ts=%0d want 1/%0d", deadlock, rpt.report_timestamp, want);
        else pass_cnt++;
        $display("test_timestamp: detection on edge 100, ts=%0d", rpt.report_timestamp);
    endtask

    task automatic test_random();
        logic [NMON-1:0] b;
        bit clr, rdy;
        int errs = 0, dets = 0;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            b   = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            clr = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            cycle(b, clr, rdy);
            if (rpt.report_valid) dets++;
            total_cnt++;
            if (deadlock !== m_latched || rpt.report_valid !== (m_latched && !m_reported) ||
                stall_cycles !== 4'(m_run) || rpt.deadlock_idx !== m_idx || rpt.report_timestamp !== m_ts) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random k=%0d dl=%b v=%b st=%0d idx=%0d ts=%0d want %b/%b/%0d/%0d/%0d",
                             k, deadlock, rpt.report_valid, stall_cycles, rpt.deadlock_idx, rpt.report_timestamp,
                             m_latched, m_latched && !m_reported, m_run, m_idx, m_ts);
            end else pass_cnt++;
        end
        $display("test_random: 800 cycles, %0d valid cycles, %0d mismatching cycles", dets, errs);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_detect();
        test_gap();
        test_handshake();
        test_saturate_clear();
        test_async_reset();
        test_timestamp();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/photon_fifo_merger_hls_deadlock_report.md
PHOTON_FIFO_MERGER_HLS_DEADLOCK_REPORT -- requirements
Module: photon_fifo_merger_hls_deadlock_report

Interface
REQ-001 SHALL have parameter NUM_MONITORS, default 4, number of per-instance deadlock monitor block outputs consumed.
REQ-002 SHALL have parameter THRESHOLD, default 1024, consecutive blocked cycles before deadlock is declared; legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port block_in, input, NUM_MONITORS: bit i = block output of monitor i.
REQ-007 SHALL have port clear, input, 1: single-cycle request to rearm detection.
REQ-008 SHALL have port deadlock, output, 1: deadlock declared and not yet cleared.
REQ-009 SHALL have port deadlock_idx, output, clog2(NUM_MONITORS) (minimum 1): lowest set block_in index at the start of the blocked run.
REQ-010 SHALL have port stall_cycles, output, CNT_W: consecutive blocked cycles, saturating at all-ones.
REQ-011 SHALL have ports report_valid (output, 1) and report_ready (input, 1): one-shot report handshake.
REQ-012 SHALL have port report_timestamp, output, 32: free-running cycle count at detection.

Function
REQ-013 SHALL implement FSM IDLE, SUSPECT, DETECTED, REPORTED.
REQ-014 IDLE: block_in != 0 SHALL move to SUSPECT, load stall_cycles=1 and latch the lowest set index into deadlock_idx.
REQ-015 SUSPECT: block_in == 0 SHALL return to IDLE with stall_cycles=0; otherwise stall_cycles SHALL increment by 1.
REQ-016 SUSPECT SHALL move to DETECTED on the edge at which stall_cycles becomes THRESHOLD, so deadlock asserts exactly THRESHOLD cycles after the first blocked cycle.
REQ-017 Changes in which block_in bits are set during a run SHALL NOT restart the count or alter deadlock_idx while block_in != 0.
REQ-018 DETECTED SHALL assert report_valid and hold deadlock_idx, report_timestamp and the valid level stable until report_ready is sampled high.
REQ-019 On report_valid & report_ready the FSM SHALL move to REPORTED and deassert report_valid the next cycle; one report per detection.
REQ-020 deadlock SHALL be high in DETECTED and REPORTED only.
REQ-021 In DETECTED/REPORTED stall_cycles SHALL keep counting while block_in != 0, saturate at 2^CNT_W-1, and hold when block_in == 0; deadlock remains latched.
REQ-022 clear SHALL take priority over every transition, forcing IDLE, stall_cycles=0, deadlock=0, report_valid=0 next cycle, including mid-handshake; a block_in high in the clear cycle SHALL be ignored.

Reset
REQ-023 reset low SHALL asynchronously force IDLE, deadlock=0, deadlock_idx=0, stall_cycles=0, report_valid=0, report_timestamp=0 and the free-running counter to 0.
REQ-024 Reset release SHALL be synchronous to clock; first evaluation on the first edge with reset high.

Configuration
REQ-025 With DEADLOCK_REPORT_TIMESTAMP_EN defined, a 32-bit wrap-around free-running counter SHALL exist and its value SHALL be latched into report_timestamp on the SUSPECT->DETECTED edge.
REQ-026 Without DEADLOCK_REPORT_TIMESTAMP_EN, the counter SHALL be absent and report_timestamp SHALL be tied to 0; all other behaviour identical.

Structure
REQ-027 FSM state enum, state encoding width and the default THRESHOLD/CNT_W constants SHALL live in shared package photon_fifo_merger_deadlock_pkg.
REQ-028 The lowest-set-bit index encoder SHALL be sub-module photon_fifo_merger_lsb_encoder (parameter NUM_MONITORS, combinational).

Verification (THRESHOLD=8, NUM_MONITORS=4, CNT_W=4)
REQ-029 block_in=4'b0110 held 8 cycles -> deadlock and report_valid high after the 8th edge, deadlock_idx=1, stall_cycles=8.
REQ-030 block_in high 7 cycles, low 1, high 7 -> deadlock never asserts, stall_cycles returns to 0 at the gap.
REQ-031 Detection, report_ready low 5 cycles then high 1 -> report fields stable throughout, report_valid low next cycle, deadlock stays 1.
REQ-032 Blocked 20 cycles -> stall_cycles saturates at 15; clear pulse -> next cycle deadlock=0, stall_cycles=0, IDLE.
REQ-033 reset driven low mid-SUSPECT between edges -> outputs zero immediately without a clock edge.
REQ-034 With the macro defined and detection at cycle 100 after reset -> report_timestamp=100; without the macro -> report_timestamp=0.
